// File: rtl/uart_rx_8_to_64.sv
// rtl/uart_rx_8_to_64.sv - 8N1 UART receiver packing eight bytes into a 64-bit word
module uart_rx_8_to_64 #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int IDLE_TIMEOUT = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic [63:0] data_64,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TO_END   = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           sync1, sync2, sync3;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [2:0]     byte_idx;
    logic [TW-1:0]  to_cnt;
    logic [7:0]     shift;
    logic [63:0]    staging;
    logic           start_det;

    assign start_det = sync3 & ~sync2;
    assign busy      = (state != IDLE) || (byte_idx != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync3      <= 1'b1;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            to_cnt     <= '0;
            shift      <= '0;
            staging    <= '0;
            data_64    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= uart_rxd;
            sync2      <= sync1;
            sync3      <= sync2;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (start_det) begin
                        state  <= START;
                        to_cnt <= '0;
                    end else if (byte_idx == 3'd0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_END) begin
                        // Stale partial word: drop it silently
                        to_cnt   <= '0;
                        byte_idx <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= sync2 ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        shift    <= {sync2, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (sync2) begin
                            // {~idx,3'b111} == 63 - 8*idx, top byte of this slot
                            staging[{~byte_idx, 3'b111} -: 8] <= shift;
                            if (byte_idx == 3'd7) begin
                                data_64    <= {staging[63:8], shift};
                                data_valid <= 1'b1;
                                byte_idx   <= '0;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_8_to_64.sv
// tb/tb_uart_rx_8_to_64.sv - scoreboard bench for uart_rx_8_to_64 with randomized frames
module tb_uart_rx_8_to_64;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [63:0] data_64;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    uart_rx_8_to_64 #(
        .CLK_FREQ(1_000_000),
        .BAUD(100_000),
        .IDLE_TIMEOUT(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rxd(uart_rxd),
        .data_64(data_64),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int exp_err = 0;
    int last_valid_cyc = 0;
    int stop_cyc = 0;
    logic prev_err = 1'b0;
    logic [63:0] mon_w;
    logic [7:0]  pend[$];
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid pops the oldest expected word
    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            chk("valid_err_excl", {63'd0, frame_err}, 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=%h required=none", data_64);
            end else begin
                mon_w = exp_q.pop_front();
                chk("data_64", data_64, mon_w);
            end
        end
        if (frame_err) begin
            err_cnt++;
            chk("err_width", {63'd0, prev_err}, 64'd0);
        end
        prev_err = frame_err;
    end

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (10) @(negedge clk);
    endtask

    // Reference: accepted bytes accumulate; eight make a word, first byte on top
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        logic [63:0] w;
        if (stop_ok) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                w = 64'd0;
                foreach (pend[i]) w = {w[55:0], pend[i]};
                exp_q.push_back(w);
                pend.delete();
            end
        end else begin
            pend.delete();
            exp_err++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        stop_cyc = cyc;
        drive_bit(stop_ok);
        uart_rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int v0;
    logic [7:0] rb;
    bit rok;
    int rgap;

    initial begin
        // 1: reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_data_64", data_64, 64'd0);
            chk("rst_valid", {63'd0, data_valid}, 64'd0);
            chk("rst_err", {63'd0, frame_err}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
        end
        idle(5);

        // 2: eight back-to-back frames, latency and word check
        v0 = valid_cnt;
        for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b1, 0);
        chk("no_early_valid", 64'(valid_cnt), 64'(v0));
        send_frame(8'h08, 1'b1, 0);
        idle(5);
        chk("one_valid", 64'(valid_cnt), 64'(v0 + 1));
        chk("valid_latency", 64'(last_valid_cyc - stop_cyc), 64'd8);
        chk("word_0102", data_64, 64'h0102030405060708);
        chk("busy_after_word", {63'd0, busy}, 64'd0);
        chk("err_none", 64'(err_cnt), 64'd0);

        // 3: three-clock glitch is a false start
        v0 = valid_cnt;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        chk("glitch_busy", {63'd0, busy}, 64'd0);
        chk("glitch_valid", 64'(valid_cnt), 64'(v0));
        chk("glitch_err", 64'(err_cnt), 64'(exp_err));

        // 4: bad stop bit discards the partial word
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        send_frame(8'h33, 1'b0, 5);
        idle(5);
        chk("frame_err_once", 64'(err_cnt), 64'd1);
        chk("busy_after_err", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 8; i++) send_frame(8'hA0 + 8'(i), 1'b1, 0);
        idle(5);
        chk("word_a0", data_64, 64'hA0A1A2A3A4A5A6A7);

        // 5: inter-byte timeout
        v0 = valid_cnt;
        for (int i = 0; i < 5; i++) send_frame(8'h50 + 8'(i), 1'b1, 0);
        idle(150);
        chk("busy_before_to", {63'd0, busy}, 64'd1);
        idle(100);
        chk("busy_after_to", {63'd0, busy}, 64'd0);
        chk("to_no_valid", 64'(valid_cnt), 64'(v0));
        pend.delete();
        for (int i = 0; i < 8; i++) send_frame(8'hF0 + 8'(i), 1'b1, 0);
        idle(5);
        chk("word_f0", data_64, 64'hF0F1F2F3F4F5F6F7);

        // 6: reset in the middle of the 4th byte
        for (int i = 0; i < 3; i++) send_frame(8'h60 + 8'(i), 1'b1, 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        uart_rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        chk("mid_rst_data", data_64, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_valid", {63'd0, data_valid}, 64'd0);
        chk("mid_rst_err", {63'd0, frame_err}, 64'd0);
        idle(20);
        for (int i = 0; i < 8; i++) send_frame(8'hC8 + 8'(i), 1'b1, 0);
        idle(5);
        chk("word_c8", data_64, 64'hC8C9CACBCCCDCECF);

        // Randomized traffic with occasional bad stop bits
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            rgap = rok ? $urandom_range(0, 5) : $urandom_range(3, 8);
            send_frame(rb, rok, rgap);
        end
        idle(300);
        pend.delete();
        chk("final_busy", {63'd0, busy}, 64'd0);
        chk("all_words_seen", 64'(exp_q.size()), 64'd0);
        chk("err_total", 64'(err_cnt), 64'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_8_to_64.md
Name: uart_rx_8_to_64

Overview:
- Receive end of the 64-bit serial link: UART receiver (8N1, LSB-first) plus a byte-to-word assembler.
- Recovers bytes from uart_rxd and packs 8 consecutive bytes into one 64-bit word.
- Presents the word with a one-cycle valid pulse.
- Sits at the far end of the link from the 64-to-8 transmitter path and feeds the downstream parallel consumer.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line bit rate. BAUD_DIV = CLK_FREQ/BAUD (integer division, truncated; must be >= 4).
- IDLE_TIMEOUT, 100_000: idle clocks allowed between bytes of a partial word before it is discarded.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- uart_rxd  input  1  asynchronous serial line, idle high.
- data_64  output  64  last fully assembled word; first received byte in [63:56], eighth byte in [7:0].
- data_valid  output  1  one-cycle pulse; data_64 is new in the same cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high while a frame is in progress or a partial word is held.

Behaviour:
- Reset: one clock, synchronous, active-high; rst has priority over all other events.
  - Sync flops = 1; state = IDLE; bit counter, baud counter, byte index and timeout counter = 0.
  - Shift register and staging word = 0.
  - data_64 = 0, data_valid = 0, frame_err = 0, busy = 0.
- Input sync: uart_rxd passes through a 2-flop synchronizer. Start detect is a 1->0 transition on the synchronized signal, using a third registered copy.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on start detect -> START, baud_cnt = 0.
- START: at baud_cnt == BAUD_DIV/2-1, sample the line.
  - Sample = 1: false start (glitch) -> IDLE, nothing recorded.
  - Sample = 0: baud_cnt = 0, bit_cnt = 0 -> DATA.
- DATA: every BAUD_DIV clocks (baud_cnt == BAUD_DIV-1), sample one bit into shift[7] and shift right (LSB first).
  - After the 8th sample -> STOP, baud_cnt = 0.
- STOP: at baud_cnt == BAUD_DIV-1, sample the line (mid stop bit), then -> IDLE unconditionally.
  - Sample = 1: byte accepted; staging[63-8*byte_idx -: 8] = shift; byte_idx++.
  - Sample = 0: frame_err = 1 for the next cycle. Byte dropped. byte_idx = 0, so the partial word is discarded.
- Word complete: when the accepted byte is the 8th (byte_idx was 7), in the next cycle:
  - data_64 = full word, with the 8th byte in [7:0].
  - data_valid = 1.
  - byte_idx = 0.
- data_64 holds its value until the next complete word. Partial words never appear on data_64.
- Latency: data_valid is high in the cycle after the 8th byte's stop-bit sample cycle.
- Inter-byte timeout:
  - Counter runs only in IDLE with byte_idx != 0; cleared on start detect or when byte_idx = 0.
  - On reaching IDLE_TIMEOUT: byte_idx = 0 and the partial word is discarded. No data_valid, no frame_err.
- Start edge during STOP is ignored. A new start is detected only from IDLE, so a line already low on return to IDLE waits for the next 1->0 edge.
- busy = (state != IDLE) | (byte_idx != 0).
- data_valid and frame_err are never high in the same cycle.

Test Plan:
Bench values: CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), IDLE_TIMEOUT=200.
1. Reset with uart_rxd=1 -> data_64=0, data_valid=0, frame_err=0, busy=0 for 5 cycles after rst drops.
2. Send 8 good frames, bytes 0x01..0x08, back to back:
   - exactly one data_valid pulse, in the cycle after the 8th stop sample;
   - data_64=0x0102030405060708;
   - busy then 0; frame_err never asserted.
3. Glitch uart_rxd low for 3 clocks -> FSM returns to IDLE after the START sample; no data_valid, no frame_err; busy=0.
4. Send bytes 0x11, 0x22, 0x33 with a 0 stop bit on 0x33:
   - frame_err pulses once for one cycle; busy=0 afterwards.
   - Then 8 frames 0xA0..0xA7 -> data_64=0xA0A1A2A3A4A5A6A7.
5. Send 5 good frames, hold line idle 250 clocks -> busy drops at timeout, no data_valid. Then 8 frames 0xF0..0xF7 -> data_64=0xF0F1F2F3F4F5F6F7.
6. Assert rst for 1 cycle mid-DATA of the 4th byte -> all outputs and state reset next cycle. Then 8 frames 0xC8..0xCF -> data_64=0xC8C9CACBCCCDCECF.
